// File: rtl/fc_result_writer.sv
// fc_result_writer: captures eight 32-bit lane results and requantizes each to a byte
// (round, arithmetic shift, saturate). It packs the bytes into one 64-bit word and writes
// that word to BRAM2. Status and saturation count are exposed for the AXI4-lite controller.
// Optional feature macro: FC_WRITER_RELU_EN (negative lanes clamp to 0; range [0,127]).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for i_run
// S_WAIT  | shift/base latched, waiting for i_valid from the FC engine
// S_CALC  | requantize and pack captured results, count saturated lanes
// S_WRITE | ce_2/we_2 asserted, packed word presented to BRAM2
// S_DONE  | one-cycle o_done pulse
module fc_result_writer #(
  parameter int DATA_WIDTH_AXI = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int OUT_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_run,
  input  logic [4:0]                i_shift,
  input  logic [ADDR_WIDTH-1:0]     i_base_addr,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH_AXI-1:0] i_result_0,
  input  logic [DATA_WIDTH_AXI-1:0] i_result_1,
  input  logic [DATA_WIDTH_AXI-1:0] i_result_2,
  input  logic [DATA_WIDTH_AXI-1:0] i_result_3,
  input  logic [DATA_WIDTH_AXI-1:0] i_result_4,
  input  logic [DATA_WIDTH_AXI-1:0] i_result_5,
  input  logic [DATA_WIDTH_AXI-1:0] i_result_6,
  input  logic [DATA_WIDTH_AXI-1:0] i_result_7,
  output logic                      o_idle,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [ADDR_WIDTH-1:0]     addr_2,
  output logic                      ce_2,
  output logic                      we_2,
  output logic [DATA_WIDTH-1:0]     din_2,
  output logic [15:0]               o_sat_cnt
);

  localparam int LANES = 8;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CALC, S_WRITE, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [4:0]                shift_q;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [DATA_WIDTH_AXI-1:0] res_q [LANES];
  logic [DATA_WIDTH_AXI-1:0] res_in [LANES];
  logic [DATA_WIDTH-1:0]     packed_c;
  logic [LANES-1:0]          sat_c;
  logic [3:0]                sat_num_c;
  logic [16:0]               sat_sum_c;

  // Result is {saturated, byte}. Sum is done in 33 bits so the largest rounding
  // offset added to the largest positive lane cannot overflow.
  function automatic logic [OUT_DATA_WIDTH:0] requant(input logic [DATA_WIDTH_AXI-1:0] r,
                                                      input logic [4:0] sh);
    logic signed [DATA_WIDTH_AXI:0] r_ext;
    logic signed [DATA_WIDTH_AXI:0] rnd;
    logic signed [DATA_WIDTH_AXI:0] t;
    r_ext = {r[DATA_WIDTH_AXI-1], r};
    rnd   = (sh == 5'd0) ? '0 : ($signed({{DATA_WIDTH_AXI{1'b0}}, 1'b1}) <<< (sh - 5'd1));
    t     = (r_ext + rnd) >>> sh;
`ifdef FC_WRITER_RELU_EN
    if (t < 0) t = '0;
`endif
    if (t > 127)
      requant = {1'b1, 8'h7F};
    else if (t < -128)
      requant = {1'b1, 8'h80};
    else
      requant = {1'b0, t[OUT_DATA_WIDTH-1:0]};
  endfunction

  assign res_in[0] = i_result_0;
  assign res_in[1] = i_result_1;
  assign res_in[2] = i_result_2;
  assign res_in[3] = i_result_3;
  assign res_in[4] = i_result_4;
  assign res_in[5] = i_result_5;
  assign res_in[6] = i_result_6;
  assign res_in[7] = i_result_7;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and status decode.
  always_comb begin
    state_d = state_q;
    o_idle  = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    ce_2    = 1'b0;
    we_2    = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_idle = 1'b1;
        if (i_run) state_d = S_WAIT;
      end
      S_WAIT: begin
        o_busy = 1'b1;
        if (i_valid) state_d = S_CALC;
      end
      S_CALC: begin
        o_busy  = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        o_busy  = 1'b1;
        ce_2    = 1'b1;
        we_2    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch run configuration on a start pulse accepted in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      base_q  <= '0;
    end else if (state_q == S_IDLE && i_run) begin
      shift_q <= i_shift;
      base_q  <= i_base_addr;
    end
  end

  // Capture lane results on the i_valid edge seen in WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LANES; i++) res_q[i] <= '0;
    end else if (state_q == S_WAIT && i_valid) begin
      for (int i = 0; i < LANES; i++) res_q[i] <= res_in[i];
    end
  end

  // Requantize all lanes; lane 0 lands in the most significant byte.
  always_comb begin
    logic [OUT_DATA_WIDTH:0] q;
    packed_c  = '0;
    sat_c     = '0;
    sat_num_c = '0;
    q         = '0;
    for (int i = 0; i < LANES; i++) begin
      q = requant(res_q[i], shift_q);
      packed_c[DATA_WIDTH-1-OUT_DATA_WIDTH*i -: OUT_DATA_WIDTH] = q[OUT_DATA_WIDTH-1:0];
      sat_c[i]  = q[OUT_DATA_WIDTH];
      sat_num_c = sat_num_c + {3'b000, q[OUT_DATA_WIDTH]};
    end
    sat_sum_c = {1'b0, o_sat_cnt} + {13'd0, sat_num_c};
  end

  // BRAM2 address/data register at the end of CALC and hold until the next write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_2  <= '0;
      addr_2 <= '0;
    end else if (state_q == S_CALC) begin
      din_2  <= packed_c;
      addr_2 <= base_q;
    end
  end

  // Saturation counter: cleared by an accepted i_run, bumped on entry to WRITE, sticks at max.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      o_sat_cnt <= '0;
    else if (state_q == S_IDLE && i_run)
      o_sat_cnt <= '0;
    else if (state_q == S_CALC)
      o_sat_cnt <= sat_sum_c[16] ? 16'hFFFF : sat_sum_c[15:0];
  end

endmodule

// File: tb/tb_fc_result_writer.sv
// Directed bench for fc_result_writer; expected words are hand-computed.
module tb_fc_result_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_run;
  logic [4:0]  i_shift;
  logic [31:0] i_base_addr;
  logic        i_valid;
  logic [7:0][31:0] res;
  logic        o_idle, o_busy, o_done, ce_2, we_2;
  logic [31:0] addr_2;
  logic [63:0] din_2;
  logic [15:0] o_sat_cnt;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;

  fc_result_writer dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_shift(i_shift),
    .i_base_addr(i_base_addr), .i_valid(i_valid),
    .i_result_0(res[0]), .i_result_1(res[1]), .i_result_2(res[2]), .i_result_3(res[3]),
    .i_result_4(res[4]), .i_result_5(res[5]), .i_result_6(res[6]), .i_result_7(res[7]),
    .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done), .addr_2(addr_2),
    .ce_2(ce_2), .we_2(we_2), .din_2(din_2), .o_sat_cnt(o_sat_cnt)
  );

  always #5 clk = ~clk;

  // Count write strobes away from the active edge.
  always @(negedge clk) if (we_2 === 1'b1) we_cnt++;

`ifdef FC_WRITER_RELU_EN
  localparam logic [63:0] EXP3_DIN = 64'h7F007F007F000000;
  localparam logic [15:0] EXP3_SAT = 16'd2;
  localparam logic [63:0] EXP7_DIN = 64'h0100000000000000;
`else
  localparam logic [63:0] EXP3_DIN = 64'h7F807F807F8000FF;
  localparam logic [15:0] EXP3_SAT = 16'd4;
  localparam logic [63:0] EXP7_DIN = 64'h01FF000000000000;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0][31:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][31:0] v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
    return v;
  endfunction

  // Full transaction: i_run, i_valid one cycle later, then check WRITE, DONE and IDLE.
  task automatic run_txn(input string name, input logic [4:0] sh, input logic [31:0] base,
                         input logic [7:0][31:0] r, input logic [63:0] exp_din,
                         input logic [15:0] exp_sat);
    int we0;
    we0 = we_cnt;
    i_run = 1'b1; i_shift = sh; i_base_addr = base;
    tick;
    i_run = 1'b0;
    res = r; i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    tick;
    checks++;
    if (we_2 !== 1'b1 || ce_2 !== 1'b1) begin
      failures++; $display("FAIL %s_wr_strobe: we_2=%b ce_2=%b expected 1 1", name, we_2, ce_2);
    end
    checks++;
    if (din_2 !== exp_din) begin
      failures++; $display("FAIL %s_din: got %h expected %h", name, din_2, exp_din);
    end
    checks++;
    if (addr_2 !== base) begin
      failures++; $display("FAIL %s_addr: got %h expected %h", name, addr_2, base);
    end
    checks++;
    if (o_sat_cnt !== exp_sat) begin
      failures++; $display("FAIL %s_sat: got %0d expected %0d", name, o_sat_cnt, exp_sat);
    end
    tick;
    checks++;
    if (o_done !== 1'b1 || we_2 !== 1'b0 || din_2 !== exp_din) begin
      failures++; $display("FAIL %s_done: o_done=%b we_2=%b din=%h", name, o_done, we_2, din_2);
    end
    tick;
    checks++;
    if (o_idle !== 1'b1 || o_done !== 1'b0 || (we_cnt - we0) != 1) begin
      failures++; $display("FAIL %s_end: idle=%b done=%b writes=%0d expected 1 0 1", name, o_idle, o_done, we_cnt - we0);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (o_idle !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || ce_2 !== 1'b0 || we_2 !== 1'b0 ||
        addr_2 !== 32'h0 || din_2 !== 64'h0 || o_sat_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset: idle=%b busy=%b done=%b ce=%b we=%b addr=%h din=%h sat=%h expected 1 0 0 0 0 0 0 0",
               o_idle, o_busy, o_done, ce_2, we_2, addr_2, din_2, o_sat_cnt);
    end
  endtask

  task automatic test_basic;
    run_txn("t1_pack", 5'd0, 32'h10, mk(1, 2, 3, 4, 5, 6, 7, 8), 64'h0102030405060708, 16'd0);
    run_txn("t2_round", 5'd4, 32'h14, mk(24, 24, 24, 24, 24, 24, 24, 24), 64'h0202020202020202, 16'd0);
    run_txn("t3_sat", 5'd0, 32'h18, mk(300, -300, 127, -128, 128, -129, 0, -1), EXP3_DIN, EXP3_SAT);
    run_txn("t7_shift31", 5'd31, 32'h1C, mk(32'h7FFFFFFF, 32'h80000000, 0, 0, 0, 0, 0, 0), EXP7_DIN, 16'd0);
  endtask

  task automatic test_valid_ignored;
    int we0;
    we0 = we_cnt;
    res = mk(5, 5, 5, 5, 5, 5, 5, 5);
    i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    checks++;
    if (o_idle !== 1'b1) begin
      failures++; $display("FAIL t4_valid_idle: idle=%b expected 1", o_idle);
    end
    i_run = 1'b1; i_valid = 1'b1; i_shift = 5'd0; i_base_addr = 32'h40;
    tick;
    i_run = 1'b0; i_valid = 1'b0;
    tick;
    tick;
    checks++;
    if (o_busy !== 1'b1 || we_2 !== 1'b0) begin
      failures++; $display("FAIL t4_wait: busy=%b we_2=%b expected 1 0", o_busy, we_2);
    end
    res = mk(16, 32, 48, 64, 80, 96, 112, 127);
    i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    checks++;
    if (we_2 !== 1'b0) begin
      failures++; $display("FAIL t4_calc: we_2=%b expected 0", we_2);
    end
    tick;
    checks++;
    if (we_2 !== 1'b1 || din_2 !== 64'h102030405060707F || addr_2 !== 32'h40) begin
      failures++; $display("FAIL t4_write: we=%b din=%h addr=%h expected 1 102030405060707f 40", we_2, din_2, addr_2);
    end
    tick;
    checks++;
    if (o_done !== 1'b1) begin
      failures++; $display("FAIL t4_done: o_done=%b expected 1", o_done);
    end
    tick;
    checks++;
    if ((we_cnt - we0) != 1) begin
      failures++; $display("FAIL t4_write_count: got %0d expected 1", we_cnt - we0);
    end
  endtask

  task automatic test_reset_mid;
    int we0;
    we0 = we_cnt;
    i_run = 1'b1; i_shift = 5'd0; i_base_addr = 32'h55;
    tick;
    i_run = 1'b0;
    res = mk(1, 2, 3, 4, 5, 6, 7, 8); i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    test_reset;
    #2;
    reset_n = 1'b1;
    tick;
    tick;
    tick;
    checks++;
    if ((we_cnt - we0) != 0 || o_idle !== 1'b1) begin
      failures++; $display("FAIL t5_abort: writes=%0d idle=%b expected 0 1", we_cnt - we0, o_idle);
    end
    run_txn("t5_after", 5'd0, 32'h20, mk(1, 2, 3, 4, 5, 6, 7, 8), 64'h0102030405060708, 16'd0);
  endtask

  task automatic test_run_ignored;
    i_run = 1'b1; i_shift = 5'd4; i_base_addr = 32'h30;
    tick;
    i_run = 1'b1; i_shift = 5'd0; i_base_addr = 32'h99;
    tick;
    i_run = 1'b0;
    res = mk(24, 24, 24, 24, 24, 24, 24, 24); i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    tick;
    checks++;
    if (din_2 !== 64'h0202020202020202 || addr_2 !== 32'h30) begin
      failures++; $display("FAIL t6_wait_run: din=%h addr=%h expected 0202020202020202 30", din_2, addr_2);
    end
    tick;
    tick;
    i_run = 1'b1; i_shift = 5'd0; i_base_addr = 32'h60;
    tick;
    i_run = 1'b0;
    res = mk(300, -300, 127, -128, 128, -129, 0, -1); i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    i_run = 1'b1; i_base_addr = 32'h70;
    tick;
    checks++;
    if (addr_2 !== 32'h60 || o_sat_cnt !== EXP3_SAT) begin
      failures++; $display("FAIL t6_calc_run: addr=%h sat=%0d expected 60 %0d", addr_2, o_sat_cnt, EXP3_SAT);
    end
    tick;
    tick;
    i_run = 1'b0;
    checks++;
    if (o_idle !== 1'b1 || o_sat_cnt !== EXP3_SAT) begin
      failures++; $display("FAIL t6_done_run: idle=%b sat=%0d expected 1 %0d", o_idle, o_sat_cnt, EXP3_SAT);
    end
  endtask

  initial begin
    reset_n = 1'b0; i_run = 1'b0; i_shift = '0; i_base_addr = '0; i_valid = 1'b0; res = '0;
    tick;
    tick;
    test_reset;
    reset_n = 1'b1;
    tick;
    test_basic;
    test_valid_ignored;
    test_reset_mid;
    test_run_ignored;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
